// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the mult_arbiter slice.
package mult_arb_pkg;

    localparam int MULT_W         = 32;
    localparam int PROD_W         = 64;
    localparam int MULT_ARB_N_REQ = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } mult_arb_state_t;

endpackage

// File: rtl/mult32x32.sv
// Iterative shift-add 32x32 unsigned multiplier; busy stays high for 32 cycles after start.
module mult32x32
    import mult_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MULT_W-1:0] a,
    input  logic [MULT_W-1:0] b,
    output logic              busy,
    output logic [PROD_W-1:0] product
);

    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] mcand;
    logic [MULT_W-1:0] mplier;
    logic [5:0]        cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (busy) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 6'd1;
            if (cnt == 6'd1)
                busy <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{(PROD_W-MULT_W){1'b0}}, a};
            mplier <= b;
            cnt    <= 6'd32;
            busy   <= 1'b1;
        end
    end

    assign product = acc;

endmodule

// File: rtl/mult_arb_pick.sv
// Combinational winner select for mult_arbiter.
// MULT_ARB_RR_EN selects round-robin from ptr; otherwise fixed priority, lowest index wins.
module mult_arb_pick
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = MULT_ARB_N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
`ifdef MULT_ARB_RR_EN
    input  logic [ID_W-1:0]  ptr,
`endif
    output logic [N_REQ-1:0] win_onehot,
    output logic [ID_W-1:0]  win_idx,
    output logic             win_valid
);

`ifdef MULT_ARB_RR_EN
    int unsigned j;

    // Scan from ptr upward, wrapping past N_REQ-1 back to 0.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        j          = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            j = (32'(ptr) + i) % N_REQ;
            if (!win_valid && req[j]) begin
                win_valid  = 1'b1;
                win_idx    = ID_W'(j);
                win_onehot = N_REQ'(1) << j;
            end
        end
    end
`else
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!win_valid && req[i]) begin
                win_valid  = 1'b1;
                win_idx    = ID_W'(i);
                win_onehot = N_REQ'(1) << i;
            end
        end
    end
`endif

endmodule

// File: rtl/mult_arbiter.sv
// Shares one mult32x32 between N_REQ requesters: arbitrate, issue, wait, return product.
// Define MULT_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = MULT_ARB_N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_REQ-1:0]  req,
    input  logic [MULT_W-1:0] req_a [N_REQ],
    input  logic [MULT_W-1:0] req_b [N_REQ],
    output logic [N_REQ-1:0]  grant,
    output logic [N_REQ-1:0]  done,
    output logic [PROD_W-1:0] result,
    output logic [ID_W-1:0]   result_id,
    output logic              arb_busy,
    output logic              mult_start,
    output logic [MULT_W-1:0] mult_a,
    output logic [MULT_W-1:0] mult_b,
    input  logic              mult_busy,
    input  logic [PROD_W-1:0] mult_product
);

    mult_arb_state_t  state;
    logic [ID_W-1:0]  id;
    logic [N_REQ-1:0] sel_onehot;
    logic [N_REQ-1:0] win_onehot;
    logic [ID_W-1:0]  win_idx;
    logic             win_valid;

`ifdef MULT_ARB_RR_EN
    logic [ID_W-1:0]  ptr;
`endif

    mult_arb_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req        (req),
`ifdef MULT_ARB_RR_EN
        .ptr        (ptr),
`endif
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            id         <= '0;
            sel_onehot <= '0;
            mult_a     <= '0;
            mult_b     <= '0;
            result     <= '0;
            result_id  <= '0;
`ifdef MULT_ARB_RR_EN
            ptr        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        mult_a     <= req_a[win_idx];
                        mult_b     <= req_b[win_idx];
                        id         <= win_idx;
                        sel_onehot <= win_onehot;
`ifdef MULT_ARB_RR_EN
                        ptr        <= (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
                        state      <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (mult_busy)
                        state <= RUN;
                end
                RUN: begin
                    if (!mult_busy) begin
                        result    <= mult_product;
                        result_id <= id;
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Pulses decode from state so a reset drops them on the same edge.
    assign mult_start = (state == ISSUE);
    assign grant      = (state == ISSUE) ? sel_onehot : '0;
    assign done       = (state == DONE) ? (N_REQ'(1) << result_id) : '0;
    assign arb_busy   = (state != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter driving the real mult32x32; honours MULT_ARB_RR_EN.
module tb_mult_arbiter;
    import mult_arb_pkg::*;

    localparam int N = 4;

    typedef struct {
        int          id;
        logic [63:0] prod;
    } sb_item_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [31:0]   req_a [N];
    logic [31:0]   req_b [N];
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic [63:0]   result;
    logic [1:0]    result_id;
    logic          arb_busy;
    logic          mult_start;
    logic [31:0]   mult_a;
    logic [31:0]   mult_b;
    logic          mult_busy;
    logic [63:0]   mult_product;

    int n_checks = 0;
    int n_fail   = 0;
    int grants_seen = 0;
    sb_item_t sb[$];
    int       exp_grant_q[$];

    always #5 clk = ~clk;

    mult_arbiter #(.N_REQ(N), .ID_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_a        (req_a),
        .req_b        (req_b),
        .grant        (grant),
        .done         (done),
        .result       (result),
        .result_id    (result_id),
        .arb_busy     (arb_busy),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_busy    (mult_busy),
        .mult_product (mult_product)
    );

    mult32x32 u_mult (
        .clk     (clk),
        .reset   (reset),
        .start   (mult_start),
        .a       (mult_a),
        .b       (mult_b),
        .busy    (mult_busy),
        .product (mult_product)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: grants against expected order, done pulses against the scoreboard.
    always @(negedge clk) begin
        if (grant != '0) begin
            grants_seen++;
            if (exp_grant_q.size() == 0) begin
                check("unexpected_grant", grant, '0);
            end else begin
                int e;
                e = exp_grant_q.pop_front();
                check("grant", grant, N'(1) << e);
                check("mult_start", mult_start, 1'b1);
                check("mult_a", mult_a, req_a[e]);
                check("mult_b", mult_b, req_b[e]);
            end
        end
        if (done != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_done", done, '0);
            end else begin
                sb_item_t it;
                it = sb.pop_front();
                check("done", done, N'(1) << it.id);
                check("result", result, it.prod);
                check("result_id", result_id, it.id);
            end
        end
    end

    task automatic wait_grants(input int target);
        for (int n = 0; n < 200 && grants_seen < target; n++) begin
            @(negedge clk);
            #1;
        end
        if (grants_seen < target)
            check("grant_timeout", grants_seen, target);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 400 && (sb.size() != 0 || arb_busy); n++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0)
            check("done_timeout", sb.size(), 0);
    endtask

    task automatic push_exp(input int id, input logic [63:0] prod);
        sb_item_t it;
        it.id   = id;
        it.prod = prod;
        sb.push_back(it);
        exp_grant_q.push_back(id);
    endtask

    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        int target;
        req_a[id] = a;
        req_b[id] = b;
        push_exp(id, exp);
        target  = grants_seen + 1;
        req[id] = 1'b1;
        wait_grants(target);
        req[id] = 1'b0;
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int target;
        logic [63:0] p0, p2;

        reset = 1'b1;
        req   = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i] = '0;
            req_b[i] = '0;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_grant", grant, '0);
        check("rst_done", done, '0);
        check("rst_result", result, '0);
        check("rst_result_id", result_id, '0);
        check("rst_arb_busy", arb_busy, 1'b0);
        check("rst_mult_start", mult_start, 1'b0);
        check("rst_mult_a", mult_a, '0);
        check("rst_mult_b", mult_b, '0);

        run_op(0, 32'd2, 32'd3, 64'd6);
        run_op(1, 32'd123, 32'd456, 64'd56088);
        run_op(2, 32'd10000000, 32'd10000000, 64'h0000_5AF3_107A_4000);
        run_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

        // Two requesters held across four operations.
        req_a[0] = 32'd7;          req_b[0] = 32'd9;
        req_a[2] = 32'h1234_5678;  req_b[2] = 32'h9ABC_DEF0;
        p0 = 64'(req_a[0]) * 64'(req_b[0]);
        p2 = 64'(req_a[2]) * 64'(req_b[2]);
`ifdef MULT_ARB_RR_EN
        push_exp(0, p0); push_exp(2, p2); push_exp(0, p0); push_exp(2, p2);
`else
        push_exp(0, p0); push_exp(0, p0); push_exp(0, p0); push_exp(0, p0);
`endif
        target = grants_seen + 4;
        req[0] = 1'b1;
        req[2] = 1'b1;
        wait_grants(target);
        req[0] = 1'b0;
        req[2] = 1'b0;
        wait_drain();

        // Abort an operation mid-multiply; no done may follow for it.
        req_a[1] = 32'd11;
        req_b[1] = 32'd13;
        exp_grant_q.push_back(1);
        target = grants_seen + 1;
        req[1] = 1'b1;
        wait_grants(target);
        req[1] = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_before_reset", arb_busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_arb_busy", arb_busy, 1'b0);
        check("abort_done", done, '0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_idle", arb_busy, 1'b0);
        run_op(1, 32'd5, 32'd7, 64'd35);

        check("sb_empty", sb.size(), 0);
        check("grant_q_empty", exp_grant_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Controller that shares one `mult32x32` unsigned multiplier between `N_REQ` requesters. It arbitrates pending requests and registers the winner's operands. It drives the multiplier's start/operand handshake, waits out its busy window, and returns the 64-bit product with a one-cycle done pulse to the owning requester. It sits between the client blocks and the single multiplier instance; nothing else drives the multiplier.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ID_W`, `$clog2(N_REQ)`: width of requester index.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in N_REQ: per-requester request; held high with operands stable until the matching `grant`.
- `req_a` in N_REQ×32: per-requester operand a, unpacked array.
- `req_b` in N_REQ×32: per-requester operand b, unpacked array.
- `grant` out N_REQ: one-hot, one-cycle pulse; operands accepted.
- `done` out N_REQ: one-hot, one-cycle pulse; `result` valid for that requester.
- `result` out 64: product; holds until the next `done`.
- `result_id` out ID_W: index of requester owning `result`.
- `arb_busy` out 1: high in every state except IDLE.
- `mult_start`, `mult_a[31:0]`, `mult_b[31:0]` out: to multiplier `start`, `a`, `b`.
- `mult_busy` in 1, `mult_product` in 64: from multiplier `busy`, `product`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RUN, DONE.
- IDLE: if `req` ≠ 0, pick a winner, register `req_a`/`req_b` into `mult_a`/`mult_b`, and register the winner index. Go to ISSUE. Otherwise stay in IDLE.
- ISSUE, one cycle: `mult_start`=1 and `grant[id]`=1. Go to WAIT.
- WAIT: stay until `mult_busy`=1, then go to RUN.
- RUN: stay while `mult_busy`=1. When it reads 0, capture `mult_product` into `result` and `id` into `result_id`, then go to DONE.
- DONE, one cycle: `done[result_id]`=1. Go to IDLE.
- `mult_a`/`mult_b` hold from ISSUE through RUN. They are not cleared between operations.
- Arbitration occurs only in IDLE. Requests that arrive during an operation wait.
- A requester that still holds `req` after its `grant` is treated as a new request.
- The product is a pure pass-through. There is no truncation or sign handling; operands are unsigned.

## Timing
- Reset values:
  - state IDLE
  - `grant`, `done`, `mult_start`, `arb_busy` = 0
  - `result` = 0, `result_id` = 0, `mult_a` = `mult_b` = 0
  - priority pointer = 0
- Cycle at edge 0: `req` sampled in IDLE.
- Edge 1: ISSUE, so `mult_start` and `grant` are high during cycle 1.
- Edge 2: WAIT. The multiplier samples `start`.
- After `mult_busy` falls, the next edge enters DONE.
- Latency from `req` to `done` = 4 + B cycles, where B is the number of cycles `mult_busy` is high.
- Back-to-back: DONE → IDLE → ISSUE, so there are 2 cycles from one `done` to the next `mult_start`.
- Multiple requests in the same IDLE cycle: exactly one is granted, chosen per the Configuration rule. The losers keep `req` high.
- Reset mid-operation: the FSM returns to IDLE on the same edge. Pending `grant`/`done` are dropped and no `done` is issued for the aborted operation. The multiplier shares `reset`.
- `mult_busy` high while in IDLE: ignored.

## Configuration
- `MULT_ARB_RR_EN` defined: round-robin arbitration.
  - The search starts at pointer index and wraps from N_REQ-1 to 0.
  - On each grant, pointer = winner+1 mod N_REQ.
- Not defined: fixed priority, lowest index wins. There is no pointer register.

## Structure
- Package `mult_arb_pkg` holds:
  - the state enum `mult_arb_state_t` (IDLE, ISSUE, WAIT, RUN, DONE)
  - `MULT_W`=32 and `PROD_W`=64
  - the default `N_REQ`
- One sub-module, `mult_arb_pick`: combinational winner select from `req` and pointer. It outputs one-hot and index, and contains the `MULT_ARB_RR_EN` branch.
- Top level `mult_arbiter` holds the FSM and registers. The bench instantiates it with the real `mult32x32`.

## Test plan
- Reset held 4 cycles, then released: all outputs 0, `arb_busy`=0.
- req[0], a=2, b=3: `grant[0]` one cycle later; `done[0]` with result=6, `result_id`=0.
- req[1], a=123, b=456: result=56088. Then req[2], a=b=10000000: result=100000000000000 (0x5AF3107A4000).
- req[3], a=b=0xFFFFFFFF: result=0xFFFFFFFE00000001.
- req[0] and req[2] held together over 4 operations:
  - RR: grant order 0,2,0,2.
  - Fixed: 0 each time the arbiter is in IDLE while both are held.
  - Each `done` carries the correct product.
- Reset asserted during RUN: no `done`, state IDLE next cycle. A following request completes correctly.
